pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register with valid/ready flow control, stall absorption, flush, and bubble (NOP) control gating. It generalises the fixed EX/MEM latch so that any ARMv8 pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) can use one block. Each boundary supplies its own payload and control widths, and chooses between a plain stalling register and a 2-entry skid buffer that breaks the ready path. It sits between two stage datapaths and, optionally, reports stall statistics to the hazard unit.

---
 rtl/pipe_stage_reg.sv | 128 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register with valid/ready handshake, optional 2-entry skid
// buffer, flush, control gating on bubbles and a saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] main_data_reg, skid_data_reg;
  logic [CTRL_W-1:0] main_ctrl_reg, skid_ctrl_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic              load_main, main_from_skid, load_skid;
  logic              in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // State and storage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= EMPTY;
      main_data_reg <= '0;
      main_ctrl_reg <= '0;
      skid_data_reg <= '0;
      skid_ctrl_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load_main) begin
        main_data_reg <= main_from_skid ? skid_data_reg : in_data;
        main_ctrl_reg <= main_from_skid ? skid_ctrl_reg : in_ctrl;
      end
      if (load_skid) begin
        skid_data_reg <= in_data;
        skid_ctrl_reg <= in_ctrl;
      end
      if (out_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state logic; the TWO state is only reachable when in_ready can be high
  // while out_ready is low, i.e. in skid mode.
  always_comb begin
    state_next     = state_reg;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (in_xfer) begin
          load_main  = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end else if (in_xfer) begin
          load_skid  = 1'b1;
          state_next = TWO;
        end
      end
      TWO: begin
        if (out_xfer) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_next     = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (flush) begin
      state_next     = EMPTY;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Output decode
  always_comb begin
    out_valid = (state_reg != EMPTY);
    out_data  = main_data_reg;
    out_ctrl  = out_valid ? main_ctrl_reg : '0;
    occupancy = state_reg;
    stall_cnt = stall_cnt_reg;
  end

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready breaks the combinational out_ready -> in_ready path.
      logic in_ready_reg;
      always_ff @(posedge clk) begin
        if (rst) in_ready_reg <= 1'b1;
        else     in_ready_reg <= (state_next != TWO);
      end
      assign in_ready = in_ready_reg;
    end else begin : g_plain
      assign in_ready = out_ready | ~out_valid;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: one skid-mode instance and one plain-mode instance with a 4-bit stall counter.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Skid-mode instance signals
  logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [63:0] s_in_data, s_out_data;
  logic [7:0]  s_in_ctrl, s_out_ctrl;
  logic [1:0]  s_occ;
  logic [15:0] s_stall;

  // Plain-mode instance signals
  logic        p_flush, p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [63:0] p_in_data, p_out_data;
  logic [7:0]  p_in_ctrl, p_out_ctrl;
  logic [1:0]  p_occ;
  logic [3:0]  p_stall;

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_ctrl(s_in_ctrl),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
    .occupancy(s_occ), .stall_cnt(s_stall)
  );

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(8), .SKID(0), .CNT_W(4)) u_plain (
    .clk(clk), .rst(rst), .flush(p_flush),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data), .in_ctrl(p_in_ctrl),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data), .out_ctrl(p_out_ctrl),
    .occupancy(p_occ), .stall_cnt(p_stall)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s_flush = 0; s_in_valid = 1; s_in_data = 64'hDEAD; s_in_ctrl = 8'hFF; s_out_ready = 0;
    p_flush = 0; p_in_valid = 1; p_in_data = 64'hBEEF; p_in_ctrl = 8'hFF; p_out_ready = 0;

    // Reset held two cycles with valid input present
    tick(); tick();
    check("rst_s_out_valid", 64'(s_out_valid), 64'd0);
    check("rst_s_out_ctrl",  64'(s_out_ctrl),  64'd0);
    check("rst_s_out_data",  s_out_data,       64'd0);
    check("rst_s_occ",       64'(s_occ),       64'd0);
    check("rst_s_in_ready",  64'(s_in_ready),  64'd1);
    check("rst_s_stall",     64'(s_stall),     64'd0);
    check("rst_p_out_valid", 64'(p_out_valid), 64'd0);
    check("rst_p_stall",     64'(p_stall),     64'd0);
    rst = 0; s_in_valid = 0; p_in_valid = 0; p_out_ready = 1;
    tick();
    check("post_rst_s_in_ready", 64'(s_in_ready), 64'd1);
    $display("reset: done");

    // Streaming 10 entries back to back
    s_out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      s_in_valid = 1; s_in_data = 64'(k); s_in_ctrl = 8'(k);
      tick();
      check($sformatf("stream_data_%0d", k), s_out_data, 64'(k));
      check($sformatf("stream_ctrl_%0d", k), 64'(s_out_ctrl), 64'(k));
      check($sformatf("stream_occ_%0d", k),  64'(s_occ), 64'd1);
      $display("stream: k=%0d out_data=%0h occ=%0d", k, s_out_data, s_occ);
    end
    s_in_valid = 0;
    tick();
    check("drain_valid", 64'(s_out_valid), 64'd0);
    check("drain_ctrl",  64'(s_out_ctrl),  64'd0);
    check("drain_data_hold", s_out_data, 64'd9);

    // Stall with skid: A, B, C while downstream is blocked
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 64'hA; s_in_ctrl = 8'hA1; tick();
    s_in_data = 64'hB; s_in_ctrl = 8'hB2; tick();
    s_in_data = 64'hC; s_in_ctrl = 8'hC3; tick(); tick();
    check("skid_out_a",    s_out_data,        64'hA);
    check("skid_ctrl_a",   64'(s_out_ctrl),   64'hA1);
    check("skid_occ2",     64'(s_occ),        64'd2);
    check("skid_in_ready", 64'(s_in_ready),   64'd0);
    check("skid_stall3",   64'(s_stall),      64'd3);
    $display("skid: out_data=%0h occ=%0d stall_cnt=%0d", s_out_data, s_occ, s_stall);
    s_out_ready = 1;
    #1;
    check("release_a", s_out_data, 64'hA);
    tick();
    check("release_b",     s_out_data,      64'hB);
    check("release_b_occ", 64'(s_occ),      64'd1);
    check("release_rdy",   64'(s_in_ready), 64'd1);
    tick();
    check("release_c",      s_out_data,      64'hC);
    check("release_c_ctrl", 64'(s_out_ctrl), 64'hC3);
    s_in_valid = 0;
    tick();
    check("release_empty", 64'(s_out_valid), 64'd0);
    check("release_stall", 64'(s_stall),     64'd3);
    $display("release: A,B,C drained");

    // Flush with both entries held
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = 64'hD; s_in_ctrl = 8'hD4; tick();
    s_in_data = 64'hE; s_in_ctrl = 8'hE5; tick();
    check("flush_pre_occ", 64'(s_occ), 64'd2);
    s_flush = 1; s_in_data = 64'h55; s_in_ctrl = 8'hFF;
    tick();
    s_flush = 0; s_in_valid = 0;
    check("flush_valid", 64'(s_out_valid), 64'd0);
    check("flush_ctrl",  64'(s_out_ctrl),  64'd0);
    check("flush_occ",   64'(s_occ),       64'd0);
    check("flush_rdy",   64'(s_in_ready),  64'd1);
    check("flush_stall", 64'(s_stall),     64'd5);
    s_out_ready = 1;
    tick();
    check("flush_stay_empty", 64'(s_out_valid), 64'd0);
    // Input transfer coincident with flush must be discarded
    s_in_valid = 1; s_in_data = 64'h55; s_in_ctrl = 8'h77; s_flush = 1;
    tick();
    s_flush = 0; s_in_valid = 0;
    check("flush_in_valid", 64'(s_out_valid), 64'd0);
    check("flush_in_data",  s_out_data,       64'hD);
    $display("flush: occ=%0d out_valid=%0d", s_occ, s_out_valid);

    // Plain mode: combinational ready during stall
    p_in_valid = 1; p_in_data = 64'h11; p_in_ctrl = 8'h03; p_out_ready = 0;
    tick();
    check("p_load_valid", 64'(p_out_valid), 64'd1);
    check("p_load_data",  p_out_data,       64'h11);
    p_in_data = 64'h22; p_in_ctrl = 8'h04;
    #1;
    check("p_stall_rdy", 64'(p_in_ready), 64'd0);
    tick();
    check("p_stall_data", p_out_data, 64'h11);
    p_out_ready = 1;
    #1;
    check("p_release_rdy", 64'(p_in_ready), 64'd1);
    tick();
    check("p_next_data", p_out_data,       64'h22);
    check("p_next_ctrl", 64'(p_out_ctrl),  64'h04);
    check("p_next_occ",  64'(p_occ),       64'd1);
    $display("plain: out_data=%0h stall_cnt=%0d", p_out_data, p_stall);

    // Counter saturation at 4 bits
    p_in_valid = 0; p_out_ready = 0;
    repeat (20) tick();
    check("p_sat", 64'(p_stall), 64'd15);
    p_flush = 1;
    tick();
    p_flush = 0;
    check("p_sat_flush",       64'(p_stall),     64'd15);
    check("p_flush_valid",     64'(p_out_valid), 64'd0);
    check("p_flush_ctrl",      64'(p_out_ctrl),  64'd0);
    tick();
    check("p_sat_hold", 64'(p_stall), 64'd15);
    $display("saturation: stall_cnt=%0d", p_stall);

    // Reset mid-operation
    s_in_valid = 1; s_in_data = 64'h77; s_in_ctrl = 8'h12; s_out_ready = 0;
    tick();
    check("midrst_pre_valid", 64'(s_out_valid), 64'd1);
    rst = 1; s_in_valid = 0;
    tick();
    rst = 0;
    check("midrst_valid", 64'(s_out_valid), 64'd0);
    check("midrst_data",  s_out_data,       64'd0);
    check("midrst_stall", 64'(s_stall),     64'd0);
    check("midrst_p_stall", 64'(p_stall),   64'd0);
    $display("midrst: out_valid=%0d stall_cnt=%0d", s_out_valid, s_stall);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
